// File: rtl/ft64_ins_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the FT64 instruction aligner.
interface ft64_ins_aligner_if;
   logic [63:0] fch_dat;
   logic        fch_vld;
   logic        fch_rdy;
   logic [47:0] ins_o;
   logic [2:0]  len_o;
   logic [63:0] pc_o;
   logic        ins_vld;
   logic        ins_rdy;

   modport master (output fch_dat, fch_vld, ins_rdy,
                   input  fch_rdy, ins_o, len_o, pc_o, ins_vld);
   modport slave  (input  fch_dat, fch_vld, ins_rdy,
                   output fch_rdy, ins_o, len_o, pc_o, ins_vld);
endinterface

// File: rtl/ft64_ins_aligner.sv
// Aligns variable-length FT64 instructions out of the 64-bit fetch stream.
// A 16-byte shift buffer holds fetched bytes; one instruction issues per cycle.
module ft64_ins_aligner #(
   parameter logic [63:0] RST_PC      = 64'hFFFC0100,
   parameter bit          SUPPORT_DCI = 1'b1,
   parameter logic [5:0]  CMPRSSD_OP  = 6'h2D
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pred_on,
   input  logic               flush,
   input  logic [63:0]        flush_pc,
   ft64_ins_aligner_if.slave  bus
);
   typedef enum logic {SKIP, RUN} state_t;

   state_t           state_q, state_d;
   logic [15:0][7:0] buf_q, buf_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [63:0]      pc_q, pc_d;
   logic [2:0]       skip_q, skip_d;

   logic [7:0]   head;
   logic [2:0]   len, len_o, sh;
   logic [4:0]   cnt_sh, added;
   logic [127:0] buf_sh, app;
   logic [63:0]  wrd;
   logic [47:0]  ins;
   logic         iss, acc, ins_vld, fch_rdy;

   always_comb begin
      head = buf_q[0];
      if (SUPPORT_DCI && head[5:0] == CMPRSSD_OP) len = 3'd2;
      else if (head[7:6] == 2'b00)                len = 3'd4;
      else if (head[7:6] == 2'b01)                len = 3'd6;
      else                                        len = 3'd2;
      len = len | {2'b00, pred_on};
   end

   // An empty buffer reports length 0 so idle outputs read as all-zero.
   assign len_o   = (cnt_q == 5'd0) ? 3'd0 : len;
   assign fch_rdy = (cnt_q <= 5'd8) && !flush;
   assign ins_vld = (cnt_q != 5'd0) && (cnt_q >= {2'b00, len}) && !flush;

   always_comb begin
      ins = '0;
      for (int i = 0; i < 6; i++)
         if (3'(i) < len_o) ins[8*i +: 8] = buf_q[i];
   end

   assign bus.fch_rdy = fch_rdy;
   assign bus.ins_vld = ins_vld;
   assign bus.len_o   = len_o;
   assign bus.pc_o    = pc_q;
   assign bus.ins_o   = ins;

   // Shift out the issued instruction first, then append the accepted word
   // just above the surviving bytes. Bytes above the count are kept zero so
   // the append can simply be OR-ed in.
   always_comb begin
      iss     = ins_vld && bus.ins_rdy;
      acc     = bus.fch_vld && fch_rdy;
      sh      = iss ? len : 3'd0;
      cnt_sh  = cnt_q - {2'b00, sh};
      buf_sh  = buf_q >> {sh, 3'b000};
      wrd     = (state_q == SKIP) ? (bus.fch_dat >> {skip_q, 3'b000}) : bus.fch_dat;
      added   = (state_q == SKIP) ? (5'd8 - {2'b00, skip_q}) : 5'd8;
      app     = {64'd0, wrd} << {cnt_sh, 3'b000};
      buf_d   = buf_sh | (acc ? app : 128'd0);
      cnt_d   = cnt_sh + (acc ? added : 5'd0);
      pc_d    = pc_q + {61'd0, sh};
      state_d = state_q;
      skip_d  = skip_q;
      if (acc && state_q == SKIP) begin
         state_d = RUN;
         skip_d  = 3'd0;
      end
      if (flush) begin
         buf_d   = '0;
         cnt_d   = 5'd0;
         pc_d    = flush_pc;
         state_d = SKIP;
         skip_d  = flush_pc[2:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= '0;
         cnt_q   <= 5'd0;
         pc_q    <= RST_PC;
         state_q <= SKIP;
         skip_q  <= 3'd0;
      end else begin
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         state_q <= state_d;
         skip_q  <= skip_d;
      end
   end
endmodule

// File: tb/tb_ft64_ins_aligner.sv
// Directed bench for ft64_ins_aligner: hand-computed vectors, immediate assertions.
module tb_ft64_ins_aligner;
   localparam logic [63:0] RST_PC = 64'hFFFC0100;

   logic        clk;
   logic        rst_n;
   logic        pred_on;
   logic        flush;
   logic [63:0] flush_pc;
   int          checks;
   int          failures;

   ft64_ins_aligner_if bus();

   ft64_ins_aligner #(.RST_PC(RST_PC), .SUPPORT_DCI(1'b1), .CMPRSSD_OP(6'h2D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pred_on  (pred_on),
      .flush    (flush),
      .flush_pc (flush_pc),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic [47:0] ins, input logic [2:0] len,
                       input logic [63:0] pc);
      chk({tag, "_vld"}, 64'(bus.ins_vld), 64'd1);
      chk({tag, "_ins"}, 64'(bus.ins_o), 64'(ins));
      chk({tag, "_len"}, 64'(bus.len_o), 64'(len));
      chk({tag, "_pc"}, bus.pc_o, pc);
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; pred_on = 1'b0; flush = 1'b0; flush_pc = '0;
      bus.fch_dat = '0; bus.fch_vld = 1'b0; bus.ins_rdy = 1'b0;
      #12;
      chk("rst_pc", bus.pc_o, RST_PC);
      chk("rst_vld", 64'(bus.ins_vld), 64'd0);
      chk("rst_frdy", 64'(bus.fch_rdy), 64'd1);
      chk("rst_ins", 64'(bus.ins_o), 64'd0);
      chk("rst_len", 64'(bus.len_o), 64'd0);
      chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
      rst_n = 1'b1;

      // 1: three instructions from one word at RST_PC
      tick();
      bus.fch_dat = 64'hC0C0_0004_0010_4080; bus.fch_vld = 1'b1; bus.ins_rdy = 1'b1;
      #1;
      chk("t1_frdy", 64'(bus.fch_rdy), 64'd1);
      chk("t1_empty_vld", 64'(bus.ins_vld), 64'd0);
      tick(); bus.fch_vld = 1'b0; #1;
      head("t1_a", 48'h4080, 3'd2, RST_PC);
      tick(); #1;
      head("t1_b", 48'h0004_0010, 3'd4, RST_PC + 64'd2);
      tick(); #1;
      head("t1_c", 48'hC0C0, 3'd2, RST_PC + 64'd6);
      tick(); #1;
      chk("t1_drained", 64'(bus.ins_vld), 64'd0);

      // 2: 6-byte instruction straddling a word boundary
      bus.fch_dat = 64'h5540_4480_0302_0100; bus.fch_vld = 1'b1;
      tick(); bus.fch_vld = 1'b0; #1;
      head("t2_a", 48'h0302_0100, 3'd4, 64'hFFFC0108);
      tick(); #1;
      head("t2_b", 48'h4480, 3'd2, 64'hFFFC010C);
      tick(); #1;
      chk("t2_straddle_vld", 64'(bus.ins_vld), 64'd0);
      chk("t2_straddle_len", 64'(bus.len_o), 64'd6);
      bus.fch_dat = 64'h002D_BB80_9988_7766; bus.fch_vld = 1'b1;
      tick(); bus.fch_vld = 1'b0; #1;
      head("t2_six", 48'h9988_7766_5540, 3'd6, 64'hFFFC010E);
      tick(); #1;
      head("t2_c", 48'hBB80, 3'd2, 64'hFFFC0114);
      tick(); #1;
      head("t2_dci", 48'h002D, 3'd2, 64'hFFFC0116);
      tick(); #1;
      chk("t2_drained", 64'(bus.ins_vld), 64'd0);

      // 3: flush to byte offset 5
      flush = 1'b1; flush_pc = 64'hFFFC0105; #1;
      chk("t3_flush_frdy", 64'(bus.fch_rdy), 64'd0);
      chk("t3_flush_vld", 64'(bus.ins_vld), 64'd0);
      tick(); flush = 1'b0; #1;
      chk("t3_pc", bus.pc_o, 64'hFFFC0105);
      chk("t3_frdy", 64'(bus.fch_rdy), 64'd1);
      bus.fch_dat = 64'hC012_80FF_FFFF_FFFF; bus.fch_vld = 1'b1; bus.ins_rdy = 1'b0;
      tick(); bus.fch_vld = 1'b0; #1;
      chk("t3_cnt", 64'(dut.cnt_q), 64'd3);
      head("t3_a", 48'h1280, 3'd2, 64'hFFFC0105);
      bus.ins_rdy = 1'b1;
      tick(); #1;
      chk("t3_partial_vld", 64'(bus.ins_vld), 64'd0);
      chk("t3_partial_pc", bus.pc_o, 64'hFFFC0107);

      // 4: predication adds one byte to every length
      flush = 1'b1; flush_pc = 64'h1000; pred_on = 1'b1; bus.ins_rdy = 1'b0;
      tick(); flush = 1'b0;
      bus.fch_dat = 64'h6655_8044_3322_1100; bus.fch_vld = 1'b1;
      tick(); bus.fch_vld = 1'b0; #1;
      head("t4_len5", 48'h0044_3322_1100, 3'd5, 64'h1000);
      bus.ins_rdy = 1'b1;
      tick(); #1;
      head("t4_len3", 48'h66_5580, 3'd3, 64'h1005);
      tick(); #1;
      chk("t4_empty", 64'(bus.ins_vld), 64'd0);
      bus.fch_dat = 64'h2D06_0504_0302_0140; bus.fch_vld = 1'b1;
      tick(); bus.fch_vld = 1'b0; #1;
      head("t4_len7", 48'h0504_0302_0140, 3'd7, 64'h1008);
      tick(); #1;
      chk("t4_dci_len", 64'(bus.len_o), 64'd3);
      chk("t4_dci_vld", 64'(bus.ins_vld), 64'd0);
      chk("t4_dci_pc", bus.pc_o, 64'h100F);

      // 5: decode stalled while fetching fills the buffer to 16
      flush = 1'b1; flush_pc = 64'h2000; pred_on = 1'b0; bus.ins_rdy = 1'b0;
      tick(); flush = 1'b0;
      bus.fch_dat = 64'h0480_0380_0280_0180; bus.fch_vld = 1'b1;
      tick();
      bus.fch_dat = 64'h0880_0780_0680_0580; #1;
      chk("t5_frdy_at8", 64'(bus.fch_rdy), 64'd1);
      tick();
      bus.fch_dat = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      chk("t5_frdy_full", 64'(bus.fch_rdy), 64'd0);
      chk("t5_cnt16", 64'(dut.cnt_q), 64'd16);
      tick(); #1;
      chk("t5_cnt_hold", 64'(dut.cnt_q), 64'd16);
      head("t5_hold", 48'h0180, 3'd2, 64'h2000);
      bus.fch_vld = 1'b0; bus.ins_rdy = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         head("t5_drain", 48'(k) << 8 | 48'h80, 3'd2, 64'h2000 + 64'(2 * (k - 1)));
         tick(); #1;
      end
      chk("t5_drained", 64'(bus.ins_vld), 64'd0);
      chk("t5_pc_end", bus.pc_o, 64'h2010);

      // 6: issue and accept in the same cycle
      flush = 1'b1; flush_pc = 64'h3000; bus.ins_rdy = 1'b0;
      tick(); flush = 1'b0;
      bus.fch_dat = 64'hA280_A180_3020_1000; bus.fch_vld = 1'b1;
      tick();
      bus.fch_dat = 64'hA680_A580_A480_A380; bus.ins_rdy = 1'b1; #1;
      chk("t6_frdy", 64'(bus.fch_rdy), 64'd1);
      head("t6_a", 48'h3020_1000, 3'd4, 64'h3000);
      tick(); bus.fch_vld = 1'b0; #1;
      chk("t6_cnt12", 64'(dut.cnt_q), 64'd12);
      for (int k = 1; k <= 6; k++) begin
         head("t6_order", (48'(8'hA0 + k) << 8) | 48'h80, 3'd2, 64'h3004 + 64'(2 * (k - 1)));
         tick(); #1;
      end
      chk("t6_drained", 64'(bus.ins_vld), 64'd0);

      // flush then asynchronous reset mid-stream
      bus.fch_dat = 64'h0480_0380_0280_0180; bus.fch_vld = 1'b1; bus.ins_rdy = 1'b0;
      tick(); bus.fch_vld = 1'b0; #1;
      chk("t6_refill_vld", 64'(bus.ins_vld), 64'd1);
      flush = 1'b1; flush_pc = 64'h4000; #1;
      chk("t6_flush_vld", 64'(bus.ins_vld), 64'd0);
      chk("t6_flush_frdy", 64'(bus.fch_rdy), 64'd0);
      flush = 1'b0; #1;
      rst_n = 1'b0; #1;
      chk("t6_rst_pc", bus.pc_o, RST_PC);
      chk("t6_rst_vld", 64'(bus.ins_vld), 64'd0);
      chk("t6_rst_ins", 64'(bus.ins_o), 64'd0);
      chk("t6_rst_len", 64'(bus.len_o), 64'd0);
      chk("t6_rst_frdy", 64'(bus.fch_rdy), 64'd1);
      chk("t6_rst_cnt", 64'(dut.cnt_q), 64'd0);
      #3 rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
